pwm_meas: RTL and testbench
===========================

PWM_MEAS -- requirements
Module: pwm_meas

Interface
REQ-001 SHALL have parameter: CNT_W, 32, width of measurement counter and result registers (8..32; results zero-extended on PRDATA).
REQ-002 SHALL have ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESETn  in  1  reset; synchronous, active-low.
- PSELPWM  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  APB write.
- PADDR  in  [3:2]  register select.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data; combinational.
- PWM_IN  in  1  asynchronous PWM input to measure.
- INTpwm  out  1  level interrupt.

Function
REQ-003 SHALL decode an access when PSELPWM & PENABLE; PADDR 00 CTRL, 01 STATUS, 10 HIGH, 11 PERIOD.
REQ-004 SHALL implement CTRL (R/W): [0] EN, [1] INTE, [2] POL (1 = invert PWM_IN), [3] SINGLE, [4] OVF_INTE; other bits read 0.
REQ-005 SHALL implement STATUS: [0] DONE (sticky, W1C), [1] OVF (sticky, W1C), [2] BUSY (state not IDLE, RO), [3] LEVEL (qualified synchronized input, RO).
REQ-006 SHALL make HIGH and PERIOD read-only; writes to them are ignored.
REQ-007 SHALL drive PRDATA with the selected register on a read access, else 32'h0.
REQ-008 SHALL pass PWM_IN through two synchronizer flops, XOR with POL, and register once more for edge detection; rise = q & ~q_d, fall = ~q & q_d.
REQ-009 SHALL update FSM on the 3rd PCLK edge after the first edge sampling a new PWM_IN level.
REQ-010 SHALL implement FSM states IDLE, ARM, HI, LO.
REQ-011 IDLE: counter held 0; EN=1 -> ARM.
REQ-012 ARM: on rise, counter <= 1 -> HI.
REQ-013 HI: counter increments each cycle; on fall, hi_cap <= counter -> LO.
REQ-014 LO: counter increments; on rise, HIGH <= hi_cap, PERIOD <= counter, DONE <= 1, counter <= 1; SINGLE=0 -> HI; SINGLE=1 -> IDLE and CTRL.EN <= 0.
REQ-015 SHALL make HIGH and PERIOD equal the number of PCLK cycles between qualifying edges (30-high/70-low input gives 30/100).
REQ-016 In HI or LO, counter reaching all-ones SHALL set OVF, clear counter, go to ARM; HIGH/PERIOD unchanged.
REQ-017 EN written 0 in any state SHALL force IDLE next cycle, clear counter and hi_cap, preserve HIGH/PERIOD/STATUS.
REQ-018 A CTRL write changing POL while EN=1 and state not IDLE SHALL force ARM with counter cleared.
REQ-019 Hardware set of DONE/OVF SHALL win over a same-cycle W1C clear; a CTRL write of EN=1 SHALL win over the SINGLE auto-clear in the same cycle.
REQ-020 SHALL drive INTpwm = (DONE & INTE) | (OVF & OVF_INTE), combinational from registers.

Reset
REQ-021 On PRESETn=0 at a PCLK edge SHALL clear CTRL, STATUS, HIGH, PERIOD, counter, hi_cap, synchronizer and edge flops; state IDLE; INTpwm=0; PRDATA=0 when no read.
REQ-022 Reset mid-measurement SHALL discard the measurement; no DONE after release until a full new period.

Verification
REQ-023 CTRL=0x01, PWM_IN 30 high/70 low repeating -> after second rise HIGH=30, PERIOD=100, DONE=1, INTpwm=0; with INTE=1, INTpwm=1.
REQ-024 CTRL=0x05 (POL=1), same waveform -> HIGH=70, PERIOD=100.
REQ-025 CTRL=0x09 (SINGLE), waveform 10/40 -> HIGH=10, PERIOD=50, CTRL.EN reads 0, BUSY=0; later pulses leave registers unchanged.
REQ-026 CNT_W=8, CTRL=0x11, PWM_IN held high 400 cycles after a rise -> OVF=1, INTpwm=1, state ARM, HIGH/PERIOD still 0; write STATUS 0x2 -> OVF=0, INTpwm=0.
REQ-027 W1C of DONE (STATUS write 0x1) in the cycle LO sees a rise -> DONE stays 1; a write one cycle later -> DONE=0.
REQ-028 PRESETn low for 1 cycle while in LO -> all registers read 0; with EN rewritten, first DONE only after two further rises.

Source files
------------

// File: rtl/pwm_meas.sv
// pwm_meas: APB-accessible PWM high-time and period measurement unit
module pwm_meas #(
  parameter int CNT_W = 32
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSELPWM,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [3:2]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  input  logic        PWM_IN,
  output logic        INTpwm
);
  typedef enum logic [1:0] {IDLE, ARM, HI, LO} state_t;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_t state_q;
  logic [4:0] ctrl_q, ctrl_d;
  logic done_q, done_d, ovf_q, ovf_d;
  logic sync1_q, sync2_q, lvl_q;
  logic [CNT_W-1:0] cnt_q, hi_cap_q, high_q, period_q;
  logic wr, rd, wr_ctrl, wr_stat, lvl, rise, fall, busy, kill, ovf_hit, done_hit;
  logic unused_wdata;
  assign unused_wdata = ^PWDATA[31:5];
  assign wr = PSELPWM & PENABLE & PWRITE;
  assign rd = PSELPWM & PENABLE & ~PWRITE;
  assign wr_ctrl = wr & (PADDR == 2'd0);
  assign wr_stat = wr & (PADDR == 2'd1);
  assign lvl = sync2_q ^ ctrl_q[2];
  assign rise = lvl & ~lvl_q;
  assign fall = ~lvl & lvl_q;
  assign busy = state_q != IDLE;
  // disabling, or flipping polarity mid-measurement, abandons the current period
  assign kill = wr_ctrl & (~PWDATA[0] | (ctrl_q[0] & busy & (PWDATA[2] ^ ctrl_q[2])));
  assign ovf_hit = (state_q == HI || state_q == LO) & (&cnt_q) & ~kill;
  assign done_hit = (state_q == LO) & rise & ~(&cnt_q) & ~kill;
  assign ctrl_d = wr_ctrl ? PWDATA[4:0] : {ctrl_q[4:1], ctrl_q[0] & ~(done_hit & ctrl_q[3])};
  assign done_d = (done_q & ~(wr_stat & PWDATA[0])) | done_hit;
  assign ovf_d = (ovf_q & ~(wr_stat & PWDATA[1])) | ovf_hit;
  assign INTpwm = (done_q & ctrl_q[1]) | (ovf_q & ctrl_q[4]);
  assign PRDATA = !rd ? 32'h0 :
                  PADDR == 2'd0 ? {27'h0, ctrl_q} :
                  PADDR == 2'd1 ? {28'h0, lvl, busy, ovf_q, done_q} :
                  PADDR == 2'd2 ? 32'(high_q) : 32'(period_q);
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      ctrl_q <= '0;
      done_q <= 1'b0;
      ovf_q <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      lvl_q <= 1'b0;
      cnt_q <= '0;
      hi_cap_q <= '0;
      high_q <= '0;
      period_q <= '0;
    end else begin
      sync1_q <= PWM_IN;
      sync2_q <= sync1_q;
      // edge reference follows the new polarity so a POL write creates no false edge
      lvl_q <= sync2_q ^ ctrl_d[2];
      ctrl_q <= ctrl_d;
      done_q <= done_d;
      ovf_q <= ovf_d;
      if (done_hit) begin
        high_q <= hi_cap_q;
        period_q <= cnt_q;
      end
      if (!ctrl_d[0]) begin
        state_q <= IDLE;
        cnt_q <= '0;
        hi_cap_q <= '0;
      end else if (kill || ovf_hit) begin
        state_q <= ARM;
        cnt_q <= '0;
      end else begin
        case (state_q)
          IDLE: state_q <= ARM;
          ARM: if (rise) begin
            cnt_q <= ONE;
            state_q <= HI;
          end
          HI: begin
            cnt_q <= cnt_q + ONE;
            if (fall) begin
              hi_cap_q <= cnt_q;
              state_q <= LO;
            end
          end
          default: if (rise) begin
            cnt_q <= ONE;
            state_q <= ctrl_q[3] ? IDLE : HI;
          end else cnt_q <= cnt_q + ONE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pwm_meas.sv
// tb_pwm_meas: randomized and directed checks of pwm_meas against interval arithmetic
module tb_pwm_meas;
  logic clk = 0, rstn = 0;
  logic psel = 0, psel8 = 0, pen = 0, pwr = 0;
  logic [1:0] addr = 0;
  logic [31:0] wdata = 0, rdata, rdata8;
  logic pwm = 0, irq, irq8;
  int n_chk = 0, n_pass = 0;
  int tcount = 0, last_rise = 0, pos = 0, gh = 1, gl = 1;
  bit gen_on = 0, hold = 0;
  always #5 clk = ~clk;
  pwm_meas dut (.PCLK(clk), .PRESETn(rstn), .PSELPWM(psel), .PENABLE(pen), .PWRITE(pwr),
    .PADDR(addr), .PWDATA(wdata), .PRDATA(rdata), .PWM_IN(pwm), .INTpwm(irq));
  pwm_meas #(.CNT_W(8)) dut8 (.PCLK(clk), .PRESETn(rstn), .PSELPWM(psel8), .PENABLE(pen),
    .PWRITE(pwr), .PADDR(addr), .PWDATA(wdata), .PRDATA(rdata8), .PWM_IN(pwm), .INTpwm(irq8));
  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  task automatic tick();
    @(negedge clk);
    tcount++;
    if (gen_on) begin
      if (pos == 0) last_rise = tcount;
      pwm = (pos < gh);
      pos = (pos + 1) % (gh + gl);
    end else pwm = hold;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic apb_wr(input bit b8, input logic [1:0] a, input logic [31:0] d);
    tick();
    psel = !b8; psel8 = b8; pen = 1; pwr = 1; addr = a; wdata = d;
    tick();
    psel = 0; psel8 = 0; pen = 0; pwr = 0;
  endtask
  task automatic apb_rd(input bit b8, input logic [1:0] a, output logic [31:0] d);
    tick();
    psel = !b8; psel8 = b8; pen = 1; pwr = 0; addr = a;
    #1 d = b8 ? rdata8 : rdata;
    tick();
    psel = 0; psel8 = 0; pen = 0;
  endtask
  task automatic expect_reg(input string tag, input bit b8, input logic [1:0] a,
                            input logic [31:0] m, input logic [31:0] e);
    logic [31:0] d;
    apb_rd(b8, a, d);
    check(tag, d & m, e);
  endtask
  task automatic restart(input bit raw_idle);
    gen_on = 0; hold = raw_idle;
    apb_wr(0, 0, 0);
    apb_wr(0, 1, 3);
    repeat (4) tick();
  endtask
  // raw waveform rh high / rl low; POL=1 measures the raw low phase as "high"
  task automatic meas(input string tag, input int rh, input int rl, input bit pol, input bit inte);
    int eh, off;
    eh = pol ? rl : rh;
    off = pol ? rh : 0;
    restart(pol);
    apb_wr(0, 0, {29'h0, pol, inte, 1'b1});
    gh = rh; gl = rl; pos = 0; gen_on = 1;
    repeat (off + rh + rl + 8) tick();
    expect_reg({tag, "_high"}, 0, 2, '1, eh);
    expect_reg({tag, "_period"}, 0, 2'd3, '1, rh + rl);
    expect_reg({tag, "_status"}, 0, 1, 3, 1);
    check({tag, "_irq"}, irq, inte);
  endtask
  initial begin
    int l, t1, t2, r0;
    bit found;
    logic [31:0] d;
    repeat (3) tick();
    rstn = 1;
    for (int a = 0; a < 4; a++) expect_reg("reset_reg", 0, 2'(a), '1, 0);
    expect_reg("reset_ctrl8", 1, 0, '1, 0);
    check("reset_irq", irq, 0);
    check("reset_irq8", irq8, 0);
    // 8-bit counter overflow while input stays high
    hold = 0; repeat (4) tick();
    apb_wr(1, 0, 'h11);
    hold = 1;
    repeat (400) tick();
    expect_reg("ovf_status", 1, 1, 'hF, 'hE);
    check("ovf_irq", irq8, 1);
    expect_reg("ovf_high", 1, 2, '1, 0);
    expect_reg("ovf_period", 1, 2'd3, '1, 0);
    apb_wr(1, 1, 2);
    expect_reg("ovf_clear", 1, 1, 'hF, 'hC);
    check("ovf_clear_irq", irq8, 0);
    apb_wr(1, 0, 0);
    // 30/70 plain, interrupt enable, disable keeps results, RO writes ignored
    meas("d30", 30, 70, 0, 0);
    apb_wr(0, 0, 3);
    check("inte_irq", irq, 1);
    apb_wr(0, 0, 0);
    expect_reg("dis_high", 0, 2, '1, 30);
    expect_reg("dis_status", 0, 1, 7, 1);
    apb_wr(0, 2, 'hABCD);
    expect_reg("ro_high", 0, 2, '1, 30);
    #1 check("idle_prdata", rdata, 0);
    meas("pol", 30, 70, 1, 0);
    // single-shot 10/40, then a different waveform must not be captured
    restart(0);
    apb_wr(0, 0, 'h9);
    gh = 10; gl = 40; pos = 0; gen_on = 1;
    repeat (60) tick();
    expect_reg("single_high", 0, 2, '1, 10);
    expect_reg("single_period", 0, 2'd3, '1, 50);
    expect_reg("single_ctrl", 0, 0, '1, 'h08);
    expect_reg("single_status", 0, 1, 7, 1);
    gh = 20; gl = 30; pos = 0;
    repeat (120) tick();
    expect_reg("single_hold_high", 0, 2, '1, 10);
    expect_reg("single_hold_period", 0, 2'd3, '1, 50);
    for (int i = 0; i < 10; i++)
      meas("rnd", $urandom_range(1, 60), $urandom_range(1, 60), 1'($urandom), 1'($urandom));
    // W1C of DONE racing the hardware set, then one cycle later
    restart(0);
    apb_wr(0, 0, 1);
    gh = 10; gl = 20; pos = 0; gen_on = 1;
    psel = 1; pen = 1; pwr = 0; addr = 1;
    found = 0; l = 3;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      #1 if (rdata[0]) begin
        found = 1;
        l = tcount - last_rise;
      end
    end
    psel = 0; pen = 0;
    check("w1c_done_seen", found, 1);
    apb_wr(0, 1, 1);
    t1 = last_rise + 30;
    while (tcount < t1 + l - 2) tick();
    apb_wr(0, 1, 1);
    expect_reg("w1c_race", 0, 1, 1, 1);
    t2 = t1 + 30;
    while (tcount < t2 + l - 1) tick();
    apb_wr(0, 1, 1);
    expect_reg("w1c_after", 0, 1, 1, 0);
    // reset pulse while in LO discards the measurement in progress
    restart(0);
    apb_wr(0, 0, 1);
    gh = 30; gl = 70; pos = 0; gen_on = 1;
    tick();
    r0 = last_rise;
    while (tcount < r0 + 40) tick();
    rstn = 0;
    tick();
    rstn = 1;
    for (int a = 0; a < 4; a++) expect_reg("rst_lo_reg", 0, 2'(a), '1, 0);
    check("rst_lo_irq", irq, 0);
    apb_wr(0, 0, 1);
    while (tcount < r0 + 150) tick();
    expect_reg("rst_one_rise", 0, 1, 1, 0);
    while (tcount < r0 + 210) tick();
    expect_reg("rst_two_rises", 0, 1, 1, 1);
    expect_reg("rst_high", 0, 2, '1, 30);
    expect_reg("rst_period", 0, 2'd3, '1, 100);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
